// File: rtl/nzcv_rename_unit.sv
// nzcv_rename_unit: producer-side rename tracker for the NZCV condition flags.
// Holds architectural flags, the speculative flag value and the ROB tag of the
// youngest in-flight flag setter; dispatch reads it combinationally.
// Optional feature: define NZCV_CDB_BYPASS_EN to forward a matching CDB
// broadcast straight to the dispatch read port in the same cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// READY   | spec_nzcv holds the newest flag value; consumers get it now
// PENDING | a flag setter is in flight; consumers wait on spec_tag

module nzcv_rename_unit #(
    parameter int TAG_W = 4
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_disp_valid,
    input  logic             in_disp_sets_flags,
    input  logic [TAG_W-1:0] in_disp_tag,
    output logic             out_src_ready,
    output logic [3:0]       out_src_nzcv,
    output logic [TAG_W-1:0] out_src_tag,
    input  logic             in_cdb_valid,
    input  logic             in_cdb_sets_flags,
    input  logic [TAG_W-1:0] in_cdb_tag,
    input  logic [3:0]       in_cdb_nzcv,
    input  logic             in_commit_valid,
    input  logic             in_commit_sets_flags,
    input  logic [3:0]       in_commit_nzcv,
    input  logic             in_flush,
    output logic [3:0]       out_arch_nzcv,
    output logic             out_pending
);

    typedef enum logic {
        READY   = 1'b0,
        PENDING = 1'b1
    } mode_t;

    mode_t            mode_q, mode_d;
    logic [3:0]       spec_nzcv_q, spec_nzcv_d;
    logic [TAG_W-1:0] spec_tag_q, spec_tag_d;
    logic [3:0]       arch_nzcv_q, arch_nzcv_d;

    logic cdb_match;
    logic disp_setter;
    logic commit_we;

    assign cdb_match   = in_cdb_valid & in_cdb_sets_flags & (mode_q == PENDING) &
                         (in_cdb_tag == spec_tag_q);
    assign disp_setter = in_disp_valid & in_disp_sets_flags;
    assign commit_we   = in_commit_valid & in_commit_sets_flags;

    // Next-state: flush beats a new setter, which beats the CDB wakeup.
    always_comb begin
        mode_d      = mode_q;
        spec_nzcv_d = spec_nzcv_q;
        spec_tag_d  = spec_tag_q;
        arch_nzcv_d = commit_we ? in_commit_nzcv : arch_nzcv_q;
        if (in_flush) begin
            // Restore from the architectural value including a same-cycle commit.
            mode_d      = READY;
            spec_nzcv_d = arch_nzcv_d;
        end else if (disp_setter) begin
            mode_d     = PENDING;
            spec_tag_d = in_disp_tag;
        end else if (cdb_match) begin
            mode_d      = READY;
            spec_nzcv_d = in_cdb_nzcv;
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            mode_q      <= READY;
            spec_nzcv_q <= 4'b0000;
            spec_tag_q  <= '0;
            arch_nzcv_q <= 4'b0000;
        end else begin
            mode_q      <= mode_d;
            spec_nzcv_q <= spec_nzcv_d;
            spec_tag_q  <= spec_tag_d;
            arch_nzcv_q <= arch_nzcv_d;
        end
    end

`ifdef NZCV_CDB_BYPASS_EN
    // Dispatch read with same-cycle CDB forwarding (suppressed on flush).
    always_comb begin
        out_src_ready = (mode_q == READY);
        out_src_nzcv  = spec_nzcv_q;
        out_src_tag   = spec_tag_q;
        if (cdb_match && !in_flush) begin
            out_src_ready = 1'b1;
            out_src_nzcv  = in_cdb_nzcv;
        end
    end
`else
    // Dispatch read straight from the registers; no CDB path to the read port.
    always_comb begin
        out_src_ready = (mode_q == READY);
        out_src_nzcv  = spec_nzcv_q;
        out_src_tag   = spec_tag_q;
    end
`endif

    assign out_arch_nzcv = arch_nzcv_q;
    assign out_pending   = (mode_q == PENDING);

endmodule
